// File: rtl/l2_search_ctrl.sv
// l2_search_ctrl
// Sequences a set-associative L2 TLB lookup over a two-way entry RAM.
// A request latches a virtual address, then the controller walks every entry
// offset of the selected set, reading both ways in parallel. Read data returns
// one cycle later and is checked externally. The first hit (or a full miss)
// is captured into response registers and held until the consumer accepts it.
// In IDLE an entry write (cfg_we_i) takes priority over a lookup request.
//
// Ports
//   clk_i, rst_i                      clock, synchronous active-high reset
//   req_valid_i/req_ready_o           lookup request handshake
//   req_addr_i, req_rw_i              address to translate, 1=write 0=read
//   cfg_we_i/cfg_ready_o              entry write handshake
//   cfg_addr_i, cfg_wdata_i           entry address and data
//   hit_i, multi_hit_i, prot_i,
//   master_i, hit_addr_i              results of the external check stage
//   in_addr_o, rw_type_o              latched request
//   ram_we_o, ram_wdata_o             RAM write port
//   port0_addr_o, port1_addr_o        RAM read addresses (way 0 / way 1)
//   searching_o                       RAM read data valid for checking
//   start_search_o                    first search cycle pulse
//   offset_addr_d_o                   offset of the data being checked
//   send_outputs_o                    response consumed this cycle
//   resp_valid_o/resp_ready_i         response handshake
//   resp_*_o                          response flags and hit address
module l2_search_ctrl #(
    parameter int ADDR_WIDTH   = 32,
    parameter int PAGE_SIZE    = 4096,
    parameter int SET_WIDTH    = 5,
    parameter int OFFSET_WIDTH = 4
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  req_valid_i,
    output logic                                  req_ready_o,
    input  logic [ADDR_WIDTH-1:0]                 req_addr_i,
    input  logic                                  req_rw_i,
    input  logic                                  cfg_we_i,
    output logic                                  cfg_ready_o,
    input  logic [SET_WIDTH+OFFSET_WIDTH:0]       cfg_addr_i,
    input  logic [ADDR_WIDTH-1:0]                 cfg_wdata_i,
    input  logic                                  hit_i,
    input  logic                                  multi_hit_i,
    input  logic                                  prot_i,
    input  logic                                  master_i,
    input  logic [SET_WIDTH+OFFSET_WIDTH:0]       hit_addr_i,
    output logic [ADDR_WIDTH-1:0]                 in_addr_o,
    output logic                                  rw_type_o,
    output logic                                  ram_we_o,
    output logic [ADDR_WIDTH-1:0]                 ram_wdata_o,
    output logic [SET_WIDTH+OFFSET_WIDTH:0]       port0_addr_o,
    output logic [SET_WIDTH+OFFSET_WIDTH:0]       port1_addr_o,
    output logic                                  searching_o,
    output logic                                  start_search_o,
    output logic [OFFSET_WIDTH-1:0]               offset_addr_d_o,
    output logic                                  send_outputs_o,
    output logic                                  resp_valid_o,
    input  logic                                  resp_ready_i,
    output logic                                  resp_hit_o,
    output logic                                  resp_miss_o,
    output logic                                  resp_multi_o,
    output logic                                  resp_prot_o,
    output logic                                  resp_master_o,
    output logic [SET_WIDTH+OFFSET_WIDTH:0]       resp_hit_addr_o
);

    localparam int IGNORE_LSB = $clog2(PAGE_SIZE);
    localparam int AW         = SET_WIDTH + OFFSET_WIDTH + 1;
    localparam logic [OFFSET_WIDTH-1:0] OFFSET_MAX = {OFFSET_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t                   state;
    logic [OFFSET_WIDTH-1:0]  offset;
    logic [OFFSET_WIDTH-1:0]  offset_d;
    logic                     searching;
    logic                     start_search;
    logic [ADDR_WIDTH-1:0]    in_addr;
    logic                     rw_type;
    logic                     resp_hit;
    logic                     resp_miss;
    logic                     resp_multi;
    logic                     resp_prot;
    logic                     resp_master;
    logic [AW-1:0]            resp_hit_addr;
    logic [SET_WIDTH-1:0]     set_idx;

    assign set_idx = in_addr[IGNORE_LSB +: SET_WIDTH];

    // Lookup FSM, offset walk and response capture.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= ST_IDLE;
            offset        <= '0;
            offset_d      <= '0;
            searching     <= 1'b0;
            start_search  <= 1'b0;
            in_addr       <= '0;
            rw_type       <= 1'b0;
            resp_hit      <= 1'b0;
            resp_miss     <= 1'b0;
            resp_multi    <= 1'b0;
            resp_prot     <= 1'b0;
            resp_master   <= 1'b0;
            resp_hit_addr <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    searching    <= 1'b0;
                    start_search <= 1'b0;
                    // An entry write in the same cycle blocks the request.
                    if (req_valid_i && !cfg_we_i) begin
                        in_addr      <= req_addr_i;
                        rw_type      <= req_rw_i;
                        offset       <= '0;
                        start_search <= 1'b1;
                        state        <= ST_SEARCH;
                    end
                end
                ST_SEARCH: begin
                    start_search <= 1'b0;
                    if (searching && hit_i) begin
                        // The read issued this cycle is simply never checked.
                        resp_hit      <= 1'b1;
                        resp_miss     <= 1'b0;
                        resp_multi    <= multi_hit_i;
                        resp_prot     <= prot_i;
                        resp_master   <= master_i;
                        resp_hit_addr <= hit_addr_i;
                        searching     <= 1'b0;
                        state         <= ST_RESP;
                    end else begin
                        searching <= 1'b1;
                        offset_d  <= offset;
                        // Counter saturates at the last offset; IDLE clears it.
                        if (offset == OFFSET_MAX) begin
                            state <= ST_DRAIN;
                        end else begin
                            offset <= offset + {{(OFFSET_WIDTH-1){1'b0}}, 1'b1};
                        end
                    end
                end
                ST_DRAIN: begin
                    searching <= 1'b0;
                    if (hit_i) begin
                        resp_hit      <= 1'b1;
                        resp_miss     <= 1'b0;
                        resp_multi    <= multi_hit_i;
                        resp_prot     <= prot_i;
                        resp_master   <= master_i;
                        resp_hit_addr <= hit_addr_i;
                    end else begin
                        resp_hit      <= 1'b0;
                        resp_miss     <= 1'b1;
                        resp_multi    <= 1'b0;
                        resp_prot     <= 1'b0;
                        resp_master   <= 1'b0;
                        resp_hit_addr <= '0;
                    end
                    state <= ST_RESP;
                end
                ST_RESP: begin
                    if (resp_ready_i) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Handshake, RAM port and address muxing derived from state.
    always_comb begin
        req_ready_o  = 1'b0;
        cfg_ready_o  = 1'b0;
        ram_we_o     = 1'b0;
        ram_wdata_o  = '0;
        port0_addr_o = '0;
        port1_addr_o = '0;
        case (state)
            ST_IDLE: begin
                cfg_ready_o = 1'b1;
                if (cfg_we_i) begin
                    ram_we_o     = 1'b1;
                    ram_wdata_o  = cfg_wdata_i;
                    port0_addr_o = cfg_addr_i;
                end else begin
                    req_ready_o = 1'b1;
                end
            end
            ST_SEARCH, ST_DRAIN, ST_RESP: begin
                port0_addr_o = {1'b0, set_idx, offset};
                port1_addr_o = {1'b1, set_idx, offset};
            end
            default: begin
                port0_addr_o = '0;
            end
        endcase
    end

    assign in_addr_o       = in_addr;
    assign rw_type_o       = rw_type;
    assign searching_o     = searching;
    assign start_search_o  = start_search;
    assign offset_addr_d_o = offset_d;
    assign resp_valid_o    = (state == ST_RESP);
    assign send_outputs_o  = resp_valid_o & resp_ready_i;
    assign resp_hit_o      = resp_hit;
    assign resp_miss_o     = resp_miss;
    assign resp_multi_o    = resp_multi;
    assign resp_prot_o     = resp_prot;
    assign resp_master_o   = resp_master;
    assign resp_hit_addr_o = resp_hit_addr;

endmodule

// File: tb/tb_l2_search_ctrl.sv
module tb_l2_search_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [31:0] req_addr_i = 32'd0;
    logic        req_rw_i = 1'b0;
    logic        cfg_we_i = 1'b0;
    logic        cfg_ready_o;
    logic [9:0]  cfg_addr_i = 10'd0;
    logic [31:0] cfg_wdata_i = 32'd0;
    logic        hit_i = 1'b0, multi_hit_i = 1'b0, prot_i = 1'b0, master_i = 1'b0;
    logic [9:0]  hit_addr_i = 10'd0;
    logic [31:0] in_addr_o;
    logic        rw_type_o, ram_we_o;
    logic [31:0] ram_wdata_o;
    logic [9:0]  port0_addr_o, port1_addr_o;
    logic        searching_o, start_search_o;
    logic [3:0]  offset_addr_d_o;
    logic        send_outputs_o, resp_valid_o;
    logic        resp_ready_i = 1'b0;
    logic        resp_hit_o, resp_miss_o, resp_multi_o, resp_prot_o, resp_master_o;
    logic [9:0]  resp_hit_addr_o;

    int total = 0;
    int bad = 0;

    l2_search_ctrl dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_addr_i(req_addr_i), .req_rw_i(req_rw_i),
        .cfg_we_i(cfg_we_i), .cfg_ready_o(cfg_ready_o),
        .cfg_addr_i(cfg_addr_i), .cfg_wdata_i(cfg_wdata_i),
        .hit_i(hit_i), .multi_hit_i(multi_hit_i), .prot_i(prot_i), .master_i(master_i),
        .hit_addr_i(hit_addr_i),
        .in_addr_o(in_addr_o), .rw_type_o(rw_type_o),
        .ram_we_o(ram_we_o), .ram_wdata_o(ram_wdata_o),
        .port0_addr_o(port0_addr_o), .port1_addr_o(port1_addr_o),
        .searching_o(searching_o), .start_search_o(start_search_o),
        .offset_addr_d_o(offset_addr_d_o), .send_outputs_o(send_outputs_o),
        .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
        .resp_hit_o(resp_hit_o), .resp_miss_o(resp_miss_o), .resp_multi_o(resp_multi_o),
        .resp_prot_o(resp_prot_o), .resp_master_o(resp_master_o),
        .resp_hit_addr_o(resp_hit_addr_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // One full lookup. k = hit offset (0..15), k >= 16 means a full miss.
    // Cycle 0 is the acceptance cycle; everything expected is derived from
    // the lookup rules: issue offset c-1 in cycle c, data checked one cycle
    // later, response one cycle after the deciding check.
    task automatic run_lookup(input logic [31:0] addr, input logic rw, input int k,
                              input logic m, input logic p, input logic ms,
                              input logic [9:0] ha, input int delay);
        int set_idx = int'((addr >> 12) & 32'h1f);
        bit is_hit = (k < 16);
        int r_cyc = is_hit ? k + 3 : 18;
        int last_issue = (is_hit && (k + 2 < 16)) ? k + 2 : 16;
        logic [9:0] e0, e1;
        logic [5:0] exp_flags;
        logic [9:0] exp_ha;
        exp_flags = is_hit ? {1'b1, 1'b0, m, p, ms, 1'b0} : {1'b0, 1'b1, 4'b0000};
        exp_ha = is_hit ? ha : 10'd0;
        req_valid_i = 1'b1; req_addr_i = addr; req_rw_i = rw;
        #1;
        total++; if (req_ready_o !== 1'b1) begin bad++; $display("FAIL accept_ready got=%b exp=1", req_ready_o); end
        total++; if (ram_we_o !== 1'b0) begin bad++; $display("FAIL accept_ram_we got=%b exp=0", ram_we_o); end
        tick();
        req_valid_i = 1'b0;
        req_addr_i = $urandom;
        for (int c = 1; c <= r_cyc; c++) begin
            hit_i = (is_hit && c == k + 2);
            multi_hit_i = hit_i ? m  : 1'($urandom);
            prot_i      = hit_i ? p  : 1'($urandom);
            master_i    = hit_i ? ms : 1'($urandom);
            hit_addr_i  = hit_i ? ha : 10'($urandom);
            #1;
            total++; if (start_search_o !== (c == 1)) begin bad++; $display("FAIL start_search c=%0d got=%b exp=%b", c, start_search_o, (c == 1)); end
            total++; if (resp_valid_o !== (c == r_cyc)) begin bad++; $display("FAIL resp_valid_timing c=%0d got=%b exp=%b", c, resp_valid_o, (c == r_cyc)); end
            if (c <= last_issue) begin
                e0 = 10'(set_idx * 16 + (c - 1));
                e1 = 10'(512 + set_idx * 16 + (c - 1));
                total++; if (port0_addr_o !== e0 || port1_addr_o !== e1) begin bad++; $display("FAIL port_addr c=%0d got=%h/%h exp=%h/%h", c, port0_addr_o, port1_addr_o, e0, e1); end
            end
            if (c >= 2 && c < r_cyc) begin
                total++; if (searching_o !== 1'b1 || offset_addr_d_o !== 4'(c - 2)) begin bad++; $display("FAIL searching c=%0d got=%b/%0d exp=1/%0d", c, searching_o, offset_addr_d_o, c - 2); end
            end
            if (c < r_cyc) tick();
        end
        hit_i = 1'b0;
        total++; if (in_addr_o !== addr || rw_type_o !== rw) begin bad++; $display("FAIL latched_req got=%h/%b exp=%h/%b", in_addr_o, rw_type_o, addr, rw); end
        for (int d = 0; d <= delay; d++) begin
            resp_ready_i = (d == delay);
            #1;
            total++; if ({resp_hit_o, resp_miss_o, resp_multi_o, resp_prot_o, resp_master_o, 1'b0} !== exp_flags || resp_hit_addr_o !== exp_ha || resp_valid_o !== 1'b1) begin
                bad++; $display("FAIL resp_fields d=%0d got=%b%b%b%b%b/%h v=%b exp=%b/%h", d, resp_hit_o, resp_miss_o, resp_multi_o, resp_prot_o, resp_master_o, resp_hit_addr_o, resp_valid_o, exp_flags[5:1], exp_ha);
            end
            total++; if (send_outputs_o !== (d == delay)) begin bad++; $display("FAIL send_outputs d=%0d got=%b exp=%b", d, send_outputs_o, (d == delay)); end
            tick();
        end
        resp_ready_i = 1'b0;
        #1;
        total++; if (resp_valid_o !== 1'b0 || req_ready_o !== 1'b1 || send_outputs_o !== 1'b0) begin bad++; $display("FAIL back_to_idle got v=%b rdy=%b snd=%b exp 0/1/0", resp_valid_o, req_ready_o, send_outputs_o); end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        tick(); tick();
        rst_i = 1'b0;
        #1;
        total++; if (req_ready_o !== 1'b1 || cfg_ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b%b exp=11", req_ready_o, cfg_ready_o); end
        total++; if ({resp_valid_o, searching_o, ram_we_o, start_search_o, send_outputs_o} !== 5'b00000) begin bad++; $display("FAIL reset_ctrl got=%b exp=00000", {resp_valid_o, searching_o, ram_we_o, start_search_o, send_outputs_o}); end
        total++; if (in_addr_o !== 32'd0 || rw_type_o !== 1'b0 || resp_hit_addr_o !== 10'd0 || {resp_hit_o, resp_miss_o, resp_multi_o, resp_prot_o, resp_master_o} !== 5'b00000) begin bad++; $display("FAIL reset_regs got=%h %b %h exp=0", in_addr_o, rw_type_o, resp_hit_addr_o); end
    endtask

    task automatic test_directed_hit();
        run_lookup(32'h1234_5678, 1'b0, 3, 1'b0, 1'b0, 1'b1, 10'h1a5, 0);
    endtask

    task automatic test_full_miss();
        run_lookup(32'hdead_b000, 1'b1, 16, 1'b1, 1'b1, 1'b1, 10'h3ff, 1);
    endtask

    task automatic test_stall_prot_multi();
        run_lookup(32'h0001_f000, 1'b1, 9, 1'b1, 1'b1, 1'b0, 10'h2c9, 5);
    endtask

    task automatic test_cfg_priority();
        logic [9:0]  ca = 10'($urandom);
        logic [31:0] cd = $urandom;
        cfg_we_i = 1'b1; cfg_addr_i = ca; cfg_wdata_i = cd;
        req_valid_i = 1'b1; req_addr_i = 32'h0000_7000;
        #1;
        total++; if (ram_we_o !== 1'b1 || port0_addr_o !== ca || ram_wdata_o !== cd) begin bad++; $display("FAIL cfg_write got=%b/%h/%h exp=1/%h/%h", ram_we_o, port0_addr_o, ram_wdata_o, ca, cd); end
        total++; if (req_ready_o !== 1'b0 || cfg_ready_o !== 1'b1) begin bad++; $display("FAIL cfg_priority got rdy=%b cfg=%b exp=0/1", req_ready_o, cfg_ready_o); end
        tick();
        cfg_we_i = 1'b0;
        run_lookup(32'h0000_7000, 1'b0, 15, 1'b0, 1'b1, 1'b1, 10'h077, 0);
    endtask

    task automatic test_reset_mid();
        req_valid_i = 1'b1; req_addr_i = 32'h0000_3000;
        tick();
        req_valid_i = 1'b0;
        for (int c = 1; c < 8; c++) tick();
        #1;
        total++; if (port0_addr_o !== 10'h037) begin bad++; $display("FAIL mid_offset7 got=%h exp=037", port0_addr_o); end
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        #1;
        total++; if (searching_o !== 1'b0 || resp_valid_o !== 1'b0 || req_ready_o !== 1'b1 || start_search_o !== 1'b0) begin bad++; $display("FAIL mid_reset got s=%b v=%b r=%b st=%b", searching_o, resp_valid_o, req_ready_o, start_search_o); end
        for (int c = 0; c < 4; c++) begin
            tick();
            total++; if (resp_valid_o !== 1'b0 || send_outputs_o !== 1'b0) begin bad++; $display("FAIL mid_no_resp c=%0d got=%b%b exp=00", c, resp_valid_o, send_outputs_o); end
        end
        run_lookup(32'h0000_3000, 1'b0, 0, 1'b0, 1'b0, 1'b0, 10'h030, 0);
        // Pending response dropped by reset.
        req_valid_i = 1'b1; req_addr_i = 32'h0000_5000;
        tick();
        req_valid_i = 1'b0;
        hit_i = 1'b0;
        tick();
        hit_i = 1'b1; hit_addr_i = 10'h150;
        tick();
        hit_i = 1'b0;
        total++; if (resp_valid_o !== 1'b1) begin bad++; $display("FAIL resp_before_reset got=%b exp=1", resp_valid_o); end
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        resp_ready_i = 1'b1;
        #1;
        total++; if (resp_valid_o !== 1'b0 || send_outputs_o !== 1'b0 || resp_hit_o !== 1'b0 || resp_hit_addr_o !== 10'd0) begin bad++; $display("FAIL resp_dropped got v=%b s=%b h=%b a=%h", resp_valid_o, send_outputs_o, resp_hit_o, resp_hit_addr_o); end
        resp_ready_i = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 25; i++) begin
            run_lookup($urandom, 1'($urandom), int'($urandom_range(0, 17)),
                       1'($urandom), 1'($urandom), 1'($urandom), 10'($urandom),
                       int'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        test_reset();
        test_directed_hit();
        test_full_miss();
        test_stall_prot_multi();
        test_cfg_priority();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
